// File: rtl/mem_stage.sv
// MEM stage of the pipelined MIPS core: data-memory access over a req/ack handshake
// with timeout, upstream stall generation, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB,
  input  logic [1:0]  MEM,
  input  logic [31:0] ALUVal,
  input  logic [31:0] wdata,
  input  logic [4:0]  d_addr,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [1:0]  WB_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  d_addr_out,
  output logic        err_misalign,
  output logic        err_mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic             req_q, we_q, fault_q, err_mis_q, err_mem_q;
  logic [31:0]      addr_q, wdata_q, rcap_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       wb_out_q;
  logic [31:0]      rdata_out_q, alu_out_q;
  logic [4:0]       d_addr_out_q;

  logic is_rw, misalign, legal, illegal_op, busy;

  assign is_rw      = (MEM == 2'b10) || (MEM == 2'b01);
  assign misalign   = is_rw && (ALUVal[1:0] != 2'b00);
  assign legal      = is_rw && !misalign;
  assign illegal_op = (MEM == 2'b11);
  assign busy       = ((state_q == IDLE) && legal) || (state_q == ACCESS);
  // Gated with rst so the stall drops in the same cycle reset asserts.
  assign stall      = busy && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rcap_q    <= '0;
      fault_q   <= 1'b0;
      err_mis_q <= 1'b0;
      err_mem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fault_q <= 1'b0;
          if (legal) begin
            req_q   <= 1'b1;
            we_q    <= MEM[0];
            addr_q  <= ALUVal;
            wdata_q <= wdata;
            cnt_q   <= '0;
            rcap_q  <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            rcap_q  <= we_q ? 32'h0 : dmem_rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            req_q     <= 1'b0;
            err_mem_q <= 1'b1;
            fault_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if ((state_q == IDLE) && misalign)   err_mis_q <= 1'b1;
      if ((state_q == IDLE) && illegal_op) err_mem_q <= 1'b1;
    end
  end

  // MEM/WB register: bubble while stalled, completed access in DONE, pass-through otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_out_q     <= 2'b00;
      rdata_out_q  <= '0;
      alu_out_q    <= '0;
      d_addr_out_q <= '0;
    end else if (busy) begin
      wb_out_q <= 2'b00;
    end else begin
      alu_out_q    <= ALUVal;
      d_addr_out_q <= d_addr;
      if (state_q == DONE) begin
        wb_out_q    <= fault_q ? 2'b00 : WB;
        rdata_out_q <= rcap_q;
      end else begin
        wb_out_q    <= (misalign || illegal_op) ? 2'b00 : WB;
        rdata_out_q <= '0;
      end
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign WB_out       = wb_out_q;
  assign rdata_out    = rdata_out_q;
  assign alu_out      = alu_out_q;
  assign d_addr_out   = d_addr_out_q;
  assign err_misalign = err_mis_q;
  assign err_mem      = err_mem_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues instructions and pushes expected
// MEM/WB results; a memory responder acks requests; a monitor pops and compares.
module tb_mem_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB, MEM;
  logic [31:0] ALUVal, wdata;
  logic [4:0]  d_addr;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  WB_out;
  logic [31:0] rdata_out, alu_out;
  logic [4:0]  d_addr_out;
  logic        err_misalign, err_mem;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .WB(WB), .MEM(MEM), .ALUVal(ALUVal), .wdata(wdata),
    .d_addr(d_addr), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .WB_out(WB_out), .rdata_out(rdata_out), .alu_out(alu_out),
    .d_addr_out(d_addr_out), .err_misalign(err_misalign), .err_mem(err_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  da;
    logic        em;
    logic        ee;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // Shared between driver and memory responder.
  int          ack_k = 0;
  logic [31:0] ack_rd = '0;
  bit          stray = 0;
  bit          req_ok = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  int          req_cycles = 0;
  bit          m_mis = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the k-th cycle dmem_req is seen high (k=0: never).
  initial begin
    int cyc;
    cyc = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (stray) begin
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        stray = 0;
      end else if (dmem_req) begin
        cyc++;
        req_cycles++;
        check("req_allowed", 32'(req_ok), 32'd1);
        check("req_we", 32'(dmem_we), 32'(exp_we));
        check("req_addr", dmem_addr, exp_addr);
        if (exp_we) check("req_wdata", dmem_wdata, exp_wd);
        if (cyc == ack_k) begin
          dmem_ack = 1'b1;
          dmem_rdata = ack_rd;
        end else begin
          dmem_rdata = $urandom;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  // Monitor: every edge taken with stall low retires one instruction into MEM/WB.
  initial begin
    bit s, r;
    exp_t e;
    forever begin
      @(negedge clk);
      s = stall;
      r = rst;
      @(posedge clk);
      #1;
      if (!s && !r && q.size() > 0) begin
        e = q.pop_front();
        check("wb_out", 32'(WB_out), 32'(e.wb));
        check("alu_out", alu_out, e.alu);
        check("d_addr_out", 32'(d_addr_out), 32'(e.da));
        check("rdata_out", rdata_out, e.rd);
        check("err_misalign", 32'(err_misalign), 32'(e.em));
        check("err_mem", 32'(err_mem), 32'(e.ee));
      end
    end
  end

  // Reference model applied at issue time, then the instruction is held until it retires.
  task automatic issue(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] da, input int k,
                       input logic [31:0] rd);
    exp_t e;
    bit rw, acc, fault, s, bub;
    int exp_st, exp_rq, st, n;
    rw    = (mem == 2'b10) || (mem == 2'b01);
    acc   = rw && (alu[1:0] == 2'b00);
    fault = 0;
    e.rd  = '0;
    if (mem == 2'b11) begin
      fault = 1; m_err = 1;
    end else if (rw && !acc) begin
      fault = 1; m_mis = 1;
    end else if (acc) begin
      if (k < 1 || k > TIMEOUT) begin
        fault = 1; m_err = 1;
      end else if (mem == 2'b10) begin
        e.rd = rd;
      end
    end
    e.wb  = fault ? 2'b00 : wb;
    e.alu = alu;
    e.da  = da;
    e.em  = m_mis;
    e.ee  = m_err;
    exp_st = !acc ? 0 : ((k < 1 || k > TIMEOUT) ? TIMEOUT + 1 : k + 1);
    exp_rq = !acc ? 0 : ((k < 1 || k > TIMEOUT) ? TIMEOUT : k);
    q.push_back(e);
    WB = wb; MEM = mem; ALUVal = alu; wdata = wd; d_addr = da;
    ack_k = k; ack_rd = rd; req_ok = acc;
    exp_we = (mem == 2'b01); exp_addr = alu; exp_wd = wd;
    req_cycles = 0;
    st = 0; n = 0; bub = 1;
    forever begin
      @(negedge clk);
      s = stall;
      if (s) st++;
      @(posedge clk);
      #2;
      if (!s) break;
      if (WB_out !== 2'b00) bub = 0;
      n++;
      if (n > 100) begin
        check("retire_bound", 32'd0, 32'd1);
        break;
      end
    end
    check("stall_cycles", 32'(st), 32'(exp_st));
    check("req_cycles", 32'(req_cycles), 32'(exp_rq));
    if (acc) check("bubble_wb", 32'(bub), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_wb, r_mem;
    logic [31:0] r_alu;
    int          r_k;
    rst = 1'b1;
    WB = '0; MEM = '0; ALUVal = '0; wdata = '0; d_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_out", 32'(WB_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_errs", {30'd0, err_misalign, err_mem}, 32'd0);
    #1;
    rst = 1'b0;

    issue(2'b10, 2'b00, 32'h40, 32'h0, 5'd5, 0, 32'h0);
    issue(2'b11, 2'b10, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    issue(2'b00, 2'b01, 32'h204, 32'h12345678, 5'd0, 1, 32'hCAFEF00D);
    issue(2'b11, 2'b10, 32'h102, 32'h0, 5'd3, 2, 32'h0);
    issue(2'b10, 2'b11, 32'h80, 32'h0, 5'd4, 2, 32'h0);
    issue(2'b11, 2'b10, 32'h400, 32'h0, 5'd9, 0, 32'h0);
    stray = 1;
    issue(2'b11, 2'b10, 32'h404, 32'h0, 5'd10, 2, 32'h55AA55AA);
    issue(2'b11, 2'b10, 32'h408, 32'h0, 5'd11, TIMEOUT, 32'h0BADF00D);
    issue(2'b11, 2'b10, 32'h40C, 32'h0, 5'd12, TIMEOUT + 1, 32'h11111111);

    // Reset while a load is outstanding with sticky errors already set.
    WB = 2'b11; MEM = 2'b10; ALUVal = 32'h300; wdata = 32'h0; d_addr = 5'd13;
    ack_k = 0; req_ok = 1; exp_we = 1'b0; exp_addr = 32'h300;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_wb_out", 32'(WB_out), 32'd0);
    check("midrst_alu_out", alu_out, 32'd0);
    check("midrst_errs", {30'd0, err_misalign, err_mem}, 32'd0);
    m_mis = 0; m_err = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    MEM = 2'b00; WB = 2'b00;
    issue(2'b10, 2'b00, 32'h44, 32'h0, 5'd6, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      r_wb  = 2'($urandom);
      r_mem = 2'($urandom);
      r_alu = $urandom;
      if ($urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
      r_k = ($urandom_range(0, 15) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                         : $urandom_range(1, 5);
      issue(r_wb, r_mem, r_alu, $urandom, 5'($urandom), r_k, $urandom);
    end

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
